// File: rtl/prog_clock_divider.sv
// Multi-channel, runtime-programmable clock divider producing 50% duty slow clocks
// and tick strobes. A divisor written to a running channel is shadowed until the next toggle.
module prog_clock_divider #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned COUNT_W     = 28,
  parameter int unsigned DEFAULT_DIV = 5000000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_CH-1:0]    en,
  input  logic               wr_en,
  input  logic [3:0]         wr_chan,
  input  logic [COUNT_W-1:0] wr_div,
  output logic [N_CH-1:0]    slowClk,
  output logic [N_CH-1:0]    tick,
  output logic [N_CH-1:0]    pending
);

  logic [COUNT_W-1:0] cnt     [N_CH];
  logic [COUNT_W-1:0] div_act [N_CH];
  logic [COUNT_W-1:0] div_shd [N_CH];
  logic [N_CH-1:0]    pend_q;
  logic [N_CH-1:0]    slow_q;
  logic [N_CH-1:0]    tick_q;

  logic               wr_ok;
  logic [N_CH-1:0]    run_v;
  logic [N_CH-1:0]    tc_v;
  logic [N_CH-1:0]    hit_v;

  assign wr_ok = wr_en && (32'(wr_chan) < N_CH);

  always_comb begin
    run_v = '0;
    tc_v  = '0;
    hit_v = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      run_v[i] = en[i] && (div_act[i] != '0);
      tc_v[i]  = (cnt[i] == div_act[i] - COUNT_W'(1));
      hit_v[i] = wr_ok && (32'(wr_chan) == i);
    end
  end

  always_ff @(posedge CLK) begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (RST) begin
        cnt[i]     <= '0;
        div_act[i] <= COUNT_W'(DEFAULT_DIV);
        div_shd[i] <= '0;
        pend_q[i]  <= 1'b0;
        slow_q[i]  <= 1'b0;
        tick_q[i]  <= 1'b0;
      end else if (!run_v[i]) begin
        cnt[i]    <= '0;
        slow_q[i] <= 1'b0;
        tick_q[i] <= 1'b0;
        if (hit_v[i]) begin
          div_act[i] <= wr_div;
          pend_q[i]  <= 1'b0;
        end
      end else begin
        if (tc_v[i]) begin
          cnt[i]    <= '0;
          slow_q[i] <= ~slow_q[i];
          tick_q[i] <= 1'b1;
          if (pend_q[i]) begin
            div_act[i] <= div_shd[i];
            pend_q[i]  <= 1'b0;
          end
        end else begin
          cnt[i]    <= cnt[i] + COUNT_W'(1);
          tick_q[i] <= 1'b0;
        end
        // A write landing on the TC edge is shadowed after the old shadow is consumed.
        if (hit_v[i]) begin
          div_shd[i] <= wr_div;
          pend_q[i]  <= 1'b1;
        end
      end
    end
  end

  assign slowClk = slow_q;
  assign tick    = tick_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Bench for prog_clock_divider: countdown-style reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_prog_clock_divider;

  localparam int N  = 2;
  localparam int CW = 8;
  localparam int DD = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  en;
  logic          wr_en;
  logic [3:0]    wr_chan;
  logic [CW-1:0] wr_div;
  logic [N-1:0]  slowClk;
  logic [N-1:0]  tick;
  logic [N-1:0]  pending;

  prog_clock_divider #(.N_CH(N), .COUNT_W(CW), .DEFAULT_DIV(DD)) dut (
    .CLK(clk), .RST(rst), .en(en), .wr_en(wr_en), .wr_chan(wr_chan),
    .wr_div(wr_div), .slowClk(slowClk), .tick(tick), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: each channel counts down the cycles left in its half-period.
  int           m_left [N];
  int           m_div  [N];
  int           m_shd  [N];
  logic [N-1:0] m_slow, m_tick, m_pend;
  bit           m_valid = 0;

  always @(posedge clk) begin
    for (int c = 0; c < N; c++) begin
      bit hit;
      hit = wr_en && (int'(wr_chan) < N) && (int'(wr_chan) == c);
      if (rst) begin
        m_div[c] = DD; m_shd[c] = 0; m_pend[c] = 0;
        m_slow[c] = 0; m_tick[c] = 0; m_left[c] = DD;
      end else if (!(en[c] && m_div[c] != 0)) begin
        m_slow[c] = 0; m_tick[c] = 0;
        if (hit) begin m_div[c] = int'(wr_div); m_pend[c] = 0; end
        m_left[c] = m_div[c];
      end else begin
        m_left[c] = m_left[c] - 1;
        if (m_left[c] == 0) begin
          m_slow[c] = ~m_slow[c];
          m_tick[c] = 1;
          if (m_pend[c]) begin m_div[c] = m_shd[c]; m_pend[c] = 0; end
          m_left[c] = m_div[c];
        end else begin
          m_tick[c] = 0;
        end
        if (hit) begin m_shd[c] = int'(wr_div); m_pend[c] = 1; end
      end
    end
    if (rst) m_valid = 1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_slowClk", 32'(slowClk), 32'(m_slow));
      chk("model_tick",    32'(tick),    32'(m_tick));
      chk("model_pending", 32'(pending), 32'(m_pend));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int d);
    wr_en = 1'b1; wr_chan = 4'(ch); wr_div = CW'(d);
  endtask

  initial begin
    rst = 1'b1; en = '0; wr_en = 1'b0; wr_chan = '0; wr_div = '0;
    // Reset/default divisor
    step(2);
    chk("reset_slow", 32'(slowClk), 0);
    chk("reset_tick", 32'(tick), 0);
    chk("reset_pend", 32'(pending), 0);
    rst = 1'b0; en = 2'b11;
    step(3);
    chk("pre_rise_slow", 32'(slowClk), 0);
    step();
    chk("rise4_slow", 32'(slowClk), 32'h3);
    chk("rise4_tick", 32'(tick), 32'h3);
    step(3);
    chk("hold_slow", 32'(slowClk), 32'h3);
    chk("hold_tick", 32'(tick), 0);
    step();
    chk("fall8_slow", 32'(slowClk), 0);
    chk("fall8_tick", 32'(tick), 32'h3);
    // Mid-period reset with a simultaneous write
    step(2);
    rst = 1'b1; wr(0, 7);
    step();
    wr_en = 1'b0;
    chk("midrst_slow", 32'(slowClk), 0);
    chk("midrst_pend", 32'(pending), 0);
    rst = 1'b0;
    // Runtime change on ch0
    step();
    wr(0, 2);
    step();
    wr_en = 1'b0;
    chk("rt_pend_set", 32'(pending), 32'h1);
    step();
    chk("rt_old_half_slow", 32'(slowClk[0]), 0);
    chk("rt_old_half_pend", 32'(pending[0]), 1);
    step();
    chk("rt_tc_slow", 32'(slowClk[0]), 1);
    chk("rt_tc_pend", 32'(pending[0]), 0);
    step();
    chk("rt_new_half_mid", 32'(slowClk[0]), 1);
    step();
    chk("rt_new_half_end", 32'(slowClk[0]), 0);
    chk("rt_new_half_tick", 32'(tick[0]), 1);
    // Stopped load on ch1
    en = 2'b01;
    step();
    wr(1, 3);
    step();
    wr_en = 1'b0; en = 2'b11;
    chk("stop_load_pend", 32'(pending[1]), 0);
    step(2);
    chk("stop_load_pre", 32'(slowClk[1]), 0);
    step();
    chk("stop_load_rise", 32'(slowClk[1]), 1);
    chk("stop_load_tick", 32'(tick[1]), 1);
    chk("stop_load_nopend", 32'(pending[1]), 0);
    // Write coincident with TC, then two writes before TC
    wr(1, 5);
    step();
    wr_en = 1'b0;
    step();
    wr(1, 2);
    step();
    wr_en = 1'b0;
    chk("coll_tc_slow", 32'(slowClk[1]), 0);
    chk("coll_newshd_pend", 32'(pending[1]), 1);
    wr(1, 4);
    step();
    wr(1, 3);
    step();
    wr_en = 1'b0;
    step(2);
    chk("coll_old_shd_used", 32'(slowClk[1]), 0);
    step();
    chk("coll_half5_end", 32'(slowClk[1]), 1);
    chk("coll_pend_clr", 32'(pending[1]), 0);
    step(2);
    chk("lastwins_mid", 32'(slowClk[1]), 1);
    step();
    chk("lastwins_end", 32'(slowClk[1]), 0);
    // Out-of-range channel
    wr(5, 1);
    step();
    wr_en = 1'b0;
    chk("badchan_pend", 32'(pending), 0);
    // div=1 then write 0 to running ch0
    en = 2'b10;
    step();
    wr(0, 1);
    step();
    wr_en = 1'b0; en = 2'b11;
    step();
    chk("div1_a_slow", 32'(slowClk[0]), 1);
    chk("div1_a_tick", 32'(tick[0]), 1);
    step();
    chk("div1_b_slow", 32'(slowClk[0]), 0);
    chk("div1_b_tick", 32'(tick[0]), 1);
    step();
    chk("div1_c_slow", 32'(slowClk[0]), 1);
    wr(0, 0);
    step();
    wr_en = 1'b0;
    chk("wr0_pend", 32'(pending[0]), 1);
    step(2);
    chk("wr0_stop_slow", 32'(slowClk[0]), 0);
    chk("wr0_stop_tick", 32'(tick[0]), 0);
    chk("wr0_stop_pend", 32'(pending[0]), 0);
    step(3);
    chk("wr0_stays", 32'(slowClk[0]), 0);
    // Enable drop with pending shadow on ch1 (div_act 3)
    wr(1, 5);
    step();
    wr_en = 1'b0; en = 2'b01;
    step(10);
    chk("endrop_pend", 32'(pending[1]), 1);
    chk("endrop_slow", 32'(slowClk[1]), 0);
    en = 2'b11;
    step(2);
    chk("reen_pre", 32'(slowClk[1]), 0);
    step();
    chk("reen_rise", 32'(slowClk[1]), 1);
    chk("reen_pend_clr", 32'(pending[1]), 0);
    step(4);
    chk("reen_half5_mid", 32'(slowClk[1]), 1);
    step();
    chk("reen_half5_end", 32'(slowClk[1]), 0);
    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      rst   = ($urandom_range(0, 299) == 0);
      en[0] = ($urandom_range(0, 15) != 0);
      en[1] = ($urandom_range(0, 15) != 0);
      wr_en   = ($urandom_range(0, 7) == 0);
      wr_chan = 4'($urandom_range(0, 5));
      wr_div  = CW'($urandom_range(0, 6));
      step();
    end
    wr_en = 1'b0; rst = 1'b0;
    step(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/prog_clock_divider.md
# prog_clock_divider

Multi-channel, runtime-programmable clock divider generating N independent square-wave slow clocks plus single-cycle tick strobes from one fast clock. Successor to the fixed single-output divider: divisor width, channel count and reset divisor are parameters; divisors are reprogrammable glitch-free at runtime; each channel has its own run enable. Sits at the top of the design feeding display refresh, debouncers and slow FSMs; tick outputs are the preferred clock-enable form for logic on CLK.

## Interface
- N_CH, default 4: number of independent channels (1..16).
- COUNT_W, default 28: divisor/counter width.
- DEFAULT_DIV, default 5000000: half-period in CLK cycles loaded into every channel at reset.
- CLK  input  1  fast clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- en  input  N_CH  per-channel run enable.
- wr_en  input  1  divisor write strobe, one cycle.
- wr_chan  input  4  channel index for the write.
- wr_div  input  COUNT_W  new half-period in CLK cycles.
- slowClk  output  N_CH  per-channel divided clock (registered).
- tick  output  N_CH  one-cycle pulse coincident with each slowClk toggle.
- pending  output  N_CH  channel has a shadowed divisor not yet applied.

## Operation
- Per-channel state: cnt[COUNT_W], div_act[COUNT_W], div_shd[COUNT_W], pend, slowClk, tick.
- Running: en=1 and div_act≠0. Each cycle: if cnt == div_act−1 (terminal count, TC) then cnt←0, slowClk←~slowClk, tick←1, and if pend then div_act←div_shd, pend←0; else cnt←cnt+1, tick←0.
- Output period = 2×div_act cycles, 50% duty; div_act=1 toggles every cycle.
- Stopped: en=0 or div_act=0. cnt←0, slowClk←0, tick←0. Re-enable: first toggle (0→1) after div_act cycles.
- Write (wr_en=1, wr_chan<N_CH): if channel is running, div_shd←wr_div, pend←1 (applied at next TC, never mid-half-period). If stopped, div_act←wr_div immediately, cnt←0, pend←0.
- wr_chan ≥ N_CH: write ignored, no state change.
- Repeated writes before TC: last write wins; pend stays 1.
- Write on the same cycle as TC of that channel: TC applies the old div_shd if pend was set; the new value is shadowed (pend=1) for the following TC.
- Writing 0 to a running channel: applied at next TC, then channel stops with slowClk forced 0 the following cycle.
- en falling while pend=1: channel stops; pend and div_shd retained; div_shd applied at first TC after re-enable.
- Counter arithmetic is COUNT_W-bit unsigned; cnt never exceeds div_act−1, so no wrap.

## Timing
- Reset (RST=1 at a CLK edge, dominant over all inputs, any time including mid-period): cnt=0, div_act=DEFAULT_DIV, div_shd=0, pend=0, slowClk=0, tick=0 for all channels. RST wins over a simultaneous write.
- After RST deasserts with en=1: first slowClk rise at the edge ending cycle DEFAULT_DIV; tick high that same cycle only.
- tick and slowClk are both registered; tick is high exactly one cycle per toggle (both edges), never two consecutive cycles unless div_act=1.
- Write-to-effect latency: stopped channel, next cycle; running channel, next TC edge. pending reflects pend registered, i.e. rises the cycle after the write.
- Channels are fully independent; simultaneous TCs on several channels are legal.

## Test plan
- Reset/default: DEFAULT_DIV=4, N_CH=2, en=11 after RST -> slowClk[0] rises at cycle 4, falls at 8, period 8; tick high cycles 4 and 8 only; mid-period RST -> all outputs 0 next cycle, restart from 0.
- Runtime change: ch0 running div=4, write 2 at cnt=1 -> pending=1, current half-period still 4 cycles, then half-periods of 2; pending clears at TC.
- Stopped load: en[1]=0, write div=3 to ch1, raise en[1] -> slowClk[1] rises after 3 cycles, pending[1] never set.
- Collisions: write coincident with TC -> old shadow applied, new value shadowed; two writes before TC -> last value used; wr_chan=5 -> no channel changes.
- Edge divisors: div=1 -> toggle every cycle, tick constant 1; write 0 to running channel -> stops after current TC, slowClk=0.
- Enable drop with pending: pend=1, en=0 for 10 cycles, en=1 -> first half-period uses old div_act, shadow applied at first TC.
